// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the GPR writeback arbiter: default widths,
// writeback source IDs and the writeback request payload.
package regfile_wb_arbiter_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 5;
  localparam int unsigned DATA_WIDTH_DEF = 64;

  // Writeback source IDs, also the bit positions in req/gnt vectors
  localparam logic SRC_EXU = 1'b0;
  localparam logic SRC_LSU = 1'b1;

  // Writeback request at the default widths
  typedef struct packed {
    logic                      valid;
    logic [ADDR_WIDTH_DEF-1:0] rd;
    logic [DATA_WIDTH_DEF-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_wb_rr_arb2.sv
// Two-request round-robin arbiter. A lone request is granted directly;
// on a tie the source that did not win last time is granted.
module wb_rr_arb2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic last_q;
  logic last_d;

  // Grant selection and last-winner tracking
  always_comb begin
    gnt_o  = 2'b00;
    last_d = last_q;
    if (req_i[SRC_EXU] && req_i[SRC_LSU]) begin
      if (last_q == SRC_EXU) gnt_o[SRC_LSU] = 1'b1;
      else                   gnt_o[SRC_EXU] = 1'b1;
    end else begin
      gnt_o = req_i;
    end
    if (gnt_o[SRC_LSU])      last_d = SRC_LSU;
    else if (gnt_o[SRC_EXU]) last_d = SRC_EXU;
  end

  // Last-grant register, EXU after reset so the first tie goes to LSU
  always_ff @(posedge clk) begin
    if (rst) last_q <= SRC_EXU;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// GPR writeback arbiter: merges EXU and LSU results onto the register
// file's single write port through one registered stage, and keeps the
// per-register busy scoreboard used by decode for RAW/WAW detection.
// Optional feature macro REGFILE_WB_BYPASS_EN adds a same-cycle bypass of
// the committing write to the rs1/rs2 lookups (rs1_fwd/rs2_fwd ports).
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
`ifdef REGFILE_WB_BYPASS_EN
  ,
  output logic [DATA_WIDTH-1:0] rs1_fwd,
  output logic [DATA_WIDTH-1:0] rs2_fwd
`endif
);

  localparam int unsigned NREGS = 2 ** ADDR_WIDTH;

  // Request payload at this instance's widths
  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
  } req_t;

  req_t       exu_req;
  req_t       lsu_req;
  req_t       sel_req;
  logic [1:0] gnt;
  logic       any_gnt;

  logic                  rf_wen_q,   rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

  logic [NREGS-1:0] busy_q, busy_d;
  logic             issue_fire;

  // Pack source requests
  always_comb begin
    exu_req.valid = exu_valid;
    exu_req.rd    = exu_rd;
    exu_req.data  = exu_data;
    lsu_req.valid = lsu_valid;
    lsu_req.rd    = lsu_rd;
    lsu_req.data  = lsu_data;
  end

  wb_rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i ({lsu_req.valid, exu_req.valid}),
    .gnt_o (gnt)
  );

  // The write port drains every cycle, so ready is simply the grant
  assign exu_ready = gnt[SRC_EXU];
  assign lsu_ready = gnt[SRC_LSU];
  assign any_gnt   = |gnt;
  assign sel_req   = gnt[SRC_LSU] ? lsu_req : exu_req;

  // Output stage next state; writes to x0 are accepted but suppressed
  always_comb begin
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (any_gnt) begin
      rf_wen_d   = sel_req.valid & (sel_req.rd != '0);
      rf_waddr_d = sel_req.rd;
      rf_wdata_d = sel_req.data;
    end
  end

  // Output stage register; reset drops any in-flight result
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  // Issue is allowed unless its destination already has a pending write
  assign issue_ready = (issue_rd == '0) | ~busy_q[issue_rd];
  assign issue_fire  = issue_valid & issue_ready & (issue_rd != '0);

  // Scoreboard next state: commit clears, issue sets, set has priority
  always_comb begin
    busy_d = busy_q;
    if (rf_wen_q)   busy_d[rf_waddr_q] = 1'b0;
    if (issue_fire) busy_d[issue_rd]   = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

`ifdef REGFILE_WB_BYPASS_EN
  logic rs1_hit;
  logic rs2_hit;

  // Source lookup with same-cycle bypass of the committing write
  always_comb begin
    rs1_hit  = rf_wen_q & (rf_waddr_q == rs1_addr) & (rs1_addr != '0);
    rs2_hit  = rf_wen_q & (rf_waddr_q == rs2_addr) & (rs2_addr != '0);
    rs1_busy = busy_q[rs1_addr] & ~rs1_hit;
    rs2_busy = busy_q[rs2_addr] & ~rs2_hit;
    rs1_fwd  = rs1_hit ? rf_wdata_q : '0;
    rs2_fwd  = rs2_hit ? rf_wdata_q : '0;
  end
`else
  // Source lookup; a register stays busy through its commit cycle
  always_comb begin
    rs1_busy = busy_q[rs1_addr];
    rs2_busy = busy_q[rs2_addr];
  end
`endif

endmodule
